// File: rtl/seq_mul64.sv
// Iterative shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH in WIDTH cycles.
// The product register updates only on completion, so it can feed a result register directly.
module seq_mul64 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mq_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   sum;
  logic             last_iter;

  // One extra bit keeps the carry, which shifts into the accumulator MSB.
  assign sum       = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, mcand_reg} : '0);
  assign last_iter = (cnt_reg == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg <= '0;
      acc_reg   <= '0;
      mq_reg    <= '0;
      cnt_reg   <= '0;
      product   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg <= a;
            mq_reg    <= b;
            acc_reg   <= '0;
            cnt_reg   <= CW'(WIDTH);
          end
        end
        BUSY: begin
          acc_reg <= sum[WIDTH:1];
          mq_reg  <= {sum[0], mq_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg - CW'(1);
          // Final shifted {acc,mq} goes straight to the output; no partials escape.
          if (last_iter) product <= {sum, mq_reg[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
